// File: rtl/font_arb_pkg.sv
// font_arb_pkg: shared widths, latencies, FSM state and read-return tag for font_rom_arbiter
package font_arb_pkg;
  localparam int FONT_ADDR_W = 11;
  localparam int FONT_DATA_W = 8;
  localparam int ROM_LAT = 1;
  localparam int RET_LAT = 3;
  typedef enum logic {ARB, LOCK} state_t;
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } tag_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder, first set request at or above ptr (wrapping) wins
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] win,
  output logic [1:0]      idx
);
  logic            found;
  logic [NREQ-1:0] bit_j;
  int              j;
  // scan NREQ positions starting at ptr, keep the first hit
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    bit_j = '0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      bit_j = NREQ'(1) << j;
      if (!found && (req & bit_j) != '0) begin
        found = 1'b1;
        win = bit_j;
        idx = 2'(j);
      end
    end
  end
endmodule

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: round-robin/lock arbiter sharing one font ROM; FONT_ARB_FIXED_PRIO_EN gives requester 0 absolute priority
module font_rom_arbiter
  import font_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = FONT_ADDR_W,
  parameter int DATA_W = FONT_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ*ADDR_W-1:0] addr,
  output logic [NREQ-1:0]        gnt,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_data,
  output logic [NREQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]      rd_data
);
  localparam int TAG_STAGES = RET_LAT - ROM_LAT;
  state_t          state;
  logic [1:0]      ptr, owner, gidx, pick_idx, nxt;
  logic [NREQ-1:0] pick_req, pick_win, lock_eff, own_mask;
  logic            own_req, own_lock;
  tag_t            tq [TAG_STAGES];
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req(pick_req),
    .ptr(ptr),
    .win(pick_win),
    .idx(pick_idx)
  );
  // effective request/lock sets seen by the round robin and the owner status
  always_comb begin
`ifdef FONT_ARB_FIXED_PRIO_EN
    pick_req = req & ~NREQ'(1);
    lock_eff = lock & NREQ'(1);
`else
    pick_req = req;
    lock_eff = lock;
`endif
    own_mask = NREQ'(1) << owner;
    own_req = (req & own_mask) != '0;
    own_lock = (lock_eff & own_mask) != '0;
    nxt = (gidx == 2'(NREQ - 1)) ? 2'd0 : gidx + 2'd1;
  end
  // combinational grant: owner only while locked, otherwise the pick (suppressed in reset)
  always_comb begin
    gnt = '0;
    gidx = '0;
    if (rst && state == LOCK) begin
      gnt = req & own_mask;
      gidx = owner;
    end else if (rst) begin
`ifdef FONT_ARB_FIXED_PRIO_EN
      gnt = req[0] ? NREQ'(1) : pick_win;
      gidx = req[0] ? 2'd0 : pick_idx;
`else
      gnt = pick_win;
      gidx = pick_idx;
`endif
    end
  end
  // pointer, owner and lock state; pointer moves on every grant except those that keep the lock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB;
      ptr <= '0;
      owner <= '0;
    end else if (state == ARB) begin
      if (gnt != '0) ptr <= nxt;
      if ((gnt & lock_eff) != '0) begin
        state <= LOCK;
        owner <= gidx;
      end
    end else if (!own_req || !own_lock) begin
      state <= ARB;
      if (own_req) ptr <= nxt;
    end
  end
  // ROM address register, tag pipeline matching ROM latency, and registered read return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
      rd_valid <= '0;
      rd_data <= '0;
      for (int k = 0; k < TAG_STAGES; k++) tq[k] <= '0;
    end else begin
      if (gnt != '0) rom_addr <= ADDR_W'(addr >> (int'(gidx) * ADDR_W));
      tq[0] <= '{valid: gnt != '0, idx: gidx};
      for (int k = 1; k < TAG_STAGES; k++) tq[k] <= tq[k-1];
      rd_valid <= tq[TAG_STAGES-1].valid ? NREQ'(1) << tq[TAG_STAGES-1].idx : '0;
      if (tq[TAG_STAGES-1].valid) rd_data <= rom_data;
    end
  end
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: directed checks of grant order, lock bursts, latency, idle and reset behaviour
module tb_font_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  lock = '0;
  logic [21:0] addr = '0;
  logic [1:0]  gnt, rd_valid;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  rd_data;
  int pass_cnt = 0;
  int total = 0;

  font_rom_arbiter #(.NREQ(2)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr), .gnt(gnt),
    .rom_addr(rom_addr), .rom_data(rom_data), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] romf(input logic [10:0] a);
    return 8'(a[7:0] * 8'd37) ^ {a[10:8], 5'b10110};
  endfunction

  always @(posedge clk) rom_data <= romf(rom_addr);

  task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [10:0] a0, input logic [10:0] a1);
    @(posedge clk);
    #1;
    req = r;
    lock = l;
    addr = {a1, a0};
    @(negedge clk);
  endtask

  task automatic test_reset;
    req = 2'b11;
    @(negedge clk);
    total++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt); else pass_cnt++;
    total++; if (rom_addr !== 11'h000) $display("FAIL reset_rom_addr: got %h want 000", rom_addr); else pass_cnt++;
    total++; if (rd_valid !== 2'b00) $display("FAIL reset_rd_valid: got %b want 00", rd_valid); else pass_cnt++;
    total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 2'b00;
  endtask

  task automatic test_single;
    drive(2'b01, 2'b00, 11'h4B3, 11'h000);
    total++; if (gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", gnt); else pass_cnt++;
    drive(2'b00, 2'b00, 11'h4B3, 11'h000);
    total++; if (rom_addr !== 11'h4B3) $display("FAIL single_rom_addr: got %h want 4b3", rom_addr); else pass_cnt++;
    total++; if (rd_valid !== 2'b00) $display("FAIL single_early1: got %b want 00", rd_valid); else pass_cnt++;
    drive(2'b00, 2'b00, 11'h4B3, 11'h000);
    total++; if (rd_valid !== 2'b00) $display("FAIL single_early2: got %b want 00", rd_valid); else pass_cnt++;
    drive(2'b00, 2'b00, 11'h4B3, 11'h000);
    total++; if (rd_valid !== 2'b01) $display("FAIL single_rd_valid: got %b want 01", rd_valid); else pass_cnt++;
    total++; if (rd_data !== romf(11'h4B3)) $display("FAIL single_rd_data: got %h want %h", rd_data, romf(11'h4B3)); else pass_cnt++;
  endtask

  task automatic test_idle;
    for (int c = 0; c < 10; c++) begin
      drive(2'b00, 2'b00, 11'h3C1, 11'h123);
      total++; if (gnt !== 2'b00) $display("FAIL idle_gnt[%0d]: got %b want 00", c, gnt); else pass_cnt++;
      total++; if (rd_valid !== 2'b00) $display("FAIL idle_rd_valid[%0d]: got %b want 00", c, rd_valid); else pass_cnt++;
      total++; if (rom_addr !== 11'h4B3) $display("FAIL idle_rom_addr[%0d]: got %h want 4b3", c, rom_addr); else pass_cnt++;
    end
    drive(2'b11, 2'b00, 11'h3C1, 11'h123);
    total++; if (gnt !== 2'b10) $display("FAIL idle_ptr_gnt: got %b want 10", gnt); else pass_cnt++;
    drive(2'b00, 2'b00, 11'h3C1, 11'h123);
    total++; if (rom_addr !== 11'h123) $display("FAIL idle_rom_addr_new: got %h want 123", rom_addr); else pass_cnt++;
    drive(2'b00, 2'b00, 11'h3C1, 11'h123);
    drive(2'b00, 2'b00, 11'h3C1, 11'h123);
    total++; if (rd_valid !== 2'b10) $display("FAIL idle_rd_valid_ret: got %b want 10", rd_valid); else pass_cnt++;
    total++; if (rd_data !== romf(11'h123)) $display("FAIL idle_rd_data_ret: got %h want %h", rd_data, romf(11'h123)); else pass_cnt++;
  endtask

  task automatic test_contention;
    logic [1:0] seq [4];
    logic [7:0] exp_d;
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int c = 0; c < 7; c++) begin
      drive((c < 4) ? 2'b11 : 2'b00, 2'b00, 11'h100, 11'h2AA);
      if (c < 4) begin
        total++; if (gnt !== seq[c]) $display("FAIL cont_gnt[%0d]: got %b want %b", c, gnt, seq[c]); else pass_cnt++;
      end
      if (c >= 3) begin
        exp_d = (seq[c-3] == 2'b01) ? romf(11'h100) : romf(11'h2AA);
        total++; if (rd_valid !== seq[c-3]) $display("FAIL cont_rd_valid[%0d]: got %b want %b", c, rd_valid, seq[c-3]); else pass_cnt++;
        total++; if (rd_data !== exp_d) $display("FAIL cont_rd_data[%0d]: got %h want %h", c, rd_data, exp_d); else pass_cnt++;
      end
    end
  endtask

  task automatic test_lock_burst;
    logic [1:0] exp_g, exp_v;
    logic [7:0] exp_d;
    for (int c = 0; c < 20; c++) begin
      drive((c < 16) ? 2'b11 : (c == 16) ? 2'b10 : 2'b00, (c < 15) ? 2'b01 : 2'b00, 11'(11'h460 + c), 11'h555);
      exp_g = (c < 16) ? 2'b01 : (c == 16) ? 2'b10 : 2'b00;
      total++; if (gnt !== exp_g) $display("FAIL lock_gnt[%0d]: got %b want %b", c, gnt, exp_g); else pass_cnt++;
      exp_v = (c < 3) ? 2'b00 : (c < 19) ? 2'b01 : 2'b10;
      total++; if (rd_valid !== exp_v) $display("FAIL lock_rd_valid[%0d]: got %b want %b", c, rd_valid, exp_v); else pass_cnt++;
      if (c >= 3) begin
        exp_d = (c < 19) ? romf(11'(11'h460 + c - 3)) : romf(11'h555);
        total++; if (rd_data !== exp_d) $display("FAIL lock_rd_data[%0d]: got %h want %h", c, rd_data, exp_d); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid;
    drive(2'b01, 2'b00, 11'h7F0, 11'h0AB);
    total++; if (gnt !== 2'b01) $display("FAIL rstmid_gnt: got %b want 01", gnt); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 2'b00) $display("FAIL rstmid_gnt_in_reset: got %b want 00", gnt); else pass_cnt++;
    total++; if (rom_addr !== 11'h000) $display("FAIL rstmid_rom_addr: got %h want 000", rom_addr); else pass_cnt++;
    total++; if (rd_valid !== 2'b00) $display("FAIL rstmid_rd_valid: got %b want 00", rd_valid); else pass_cnt++;
    @(posedge clk);
    #1;
    req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 2'b10;
    @(negedge clk);
    total++; if (gnt !== 2'b10) $display("FAIL rstmid_first_gnt: got %b want 10", gnt); else pass_cnt++;
    total++; if (rd_valid !== 2'b00) $display("FAIL rstmid_stale0: got %b want 00", rd_valid); else pass_cnt++;
    for (int c = 1; c < 3; c++) begin
      drive(2'b00, 2'b00, 11'h7F0, 11'h0AB);
      total++; if (rd_valid !== 2'b00) $display("FAIL rstmid_stale%0d: got %b want 00", c, rd_valid); else pass_cnt++;
    end
    drive(2'b00, 2'b00, 11'h7F0, 11'h0AB);
    total++; if (rd_valid !== 2'b10) $display("FAIL rstmid_ret_valid: got %b want 10", rd_valid); else pass_cnt++;
    total++; if (rd_data !== romf(11'h0AB)) $display("FAIL rstmid_ret_data: got %h want %h", rd_data, romf(11'h0AB)); else pass_cnt++;
  endtask

`ifdef FONT_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio;
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 2'b00, 11'h200, 11'h300);
      total++; if (gnt !== 2'b01) $display("FAIL prio_gnt[%0d]: got %b want 01", c, gnt); else pass_cnt++;
    end
    drive(2'b10, 2'b00, 11'h200, 11'h300);
    total++; if (gnt !== 2'b10) $display("FAIL prio_gnt_req1: got %b want 10", gnt); else pass_cnt++;
    drive(2'b00, 2'b00, 11'h200, 11'h300);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_idle();
    test_contention();
    test_lock_burst();
    test_reset_mid();
`ifdef FONT_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
